// File: rtl/morse_pkg.sv
// Shared symbol codes, ASCII constants and sequencer state type for the Morse keyer front end.
package morse_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_SEND = 2'b11;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_SEND,
    ST_WORD
  } state_t;

endpackage

// File: rtl/morse_char_buf.sv
// One-entry valid/ready holding register for outgoing characters with a sticky overrun flag.
module morse_char_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         overrun_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;
  logic         accept;

  assign accept = valid_q & ready_i;

  // Load on push when the slot is free or being drained this cycle; otherwise drop and flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (push_i) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Key timing sequencer: classifies presses into dot/dash symbols for the decoder,
// captures decoded letters at end-of-letter and inserts spaces on word gaps.
module morse_keyer_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DOT_MAX    = 400,
  parameter int unsigned GAP_LETTER = 1200,
  parameter int unsigned GAP_WORD   = 2800,
  parameter int unsigned MAX_ELEM   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [1:0] symbol,
  input  logic [7:0] letter_in,
  input  logic       done_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overrun
);

  localparam int unsigned EW = $clog2(MAX_ELEM + 2);
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LETTER_C = CNT_W'(GAP_LETTER);
  localparam logic [CNT_W-1:0] GAP_WORD_C   = CNT_W'(GAP_WORD);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [EW-1:0]    MAX_ELEM_C   = EW'(MAX_ELEM);
  localparam logic [EW-1:0]    ELEM_SAT     = EW'(MAX_ELEM + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [EW-1:0]    elem_q, elem_d, elem_inc;
  logic [1:0]       sym_q, sym_d;
  logic             push;
  logic [7:0]       push_data;

  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign elem_inc = (elem_q >= ELEM_SAT) ? elem_q : elem_q + 1'b1;

  // Next-state, counters, symbol and character push decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    elem_d    = elem_q;
    sym_d     = SYM_IDLE;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_ONE;
          elem_d  = '0;
        end
      end
      ST_PRESS: begin
        if (key) begin
          cnt_d = cnt_inc;
        end else begin
          sym_d   = (cnt_q <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
          elem_d  = elem_inc;
          cnt_d   = CNT_ONE;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (key) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == GAP_LETTER_C) begin
            state_d = ST_SEND;
            sym_d   = SYM_SEND;
          end
        end
      end
      // symbol_q shows SEND during this state; the decoder still holds the letter
      // until the closing edge, so letter_in/done_in are captured on that edge.
      ST_SEND: begin
        cnt_d   = cnt_inc;
        state_d = ST_WORD;
        if (elem_q > MAX_ELEM_C) begin
          push      = 1'b1;
          push_data = ASCII_ERR;
        end else if (!done_in) begin
          push      = 1'b1;
          push_data = letter_in;
        end
      end
      ST_WORD: begin
        if (key) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_ONE;
          elem_d  = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == GAP_WORD_C) begin
            push      = 1'b1;
            push_data = ASCII_SPACE;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset holds SEND on the symbol line to restart the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      elem_q  <= '0;
      sym_q   <= SYM_SEND;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      elem_q  <= elem_d;
      sym_q   <= sym_d;
    end
  end

  assign symbol = sym_q;

  morse_char_buf #(
    .W(8)
  ) u_char_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (push),
    .data_i    (push_data),
    .ready_i   (char_ready),
    .valid_o   (char_valid),
    .data_o    (char_data),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Bench for morse_keyer_ctrl with a behavioural Morse decoder attached.
module tb_morse_keyer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic [1:0] symbol;
  logic [7:0] letter_in;
  logic       done_in;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       overrun;

  int nerr = 0;
  int nchk = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  morse_keyer_ctrl #(
    .CNT_W(16), .DOT_MAX(4), .GAP_LETTER(8), .GAP_WORD(20), .MAX_ELEM(4)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .symbol(symbol),
    .letter_in(letter_in), .done_in(done_in),
    .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .overrun(overrun)
  );

  // Morse binary tree in heap order: root 1, dot -> 2i, dash -> 2i+1. '*' = undefined code.
  function automatic logic [7:0] heap_char(input int idx);
    string t;
    t = "??ETIANMSURWDKGOHVF*L*PJBXCYZQ**";
    if (idx < 2 || idx > 31) return 8'h2A;
    return t[idx];
  endfunction

  // Decoder model: walks the tree on dot/dash, returns to root on send.
  int dec_idx = 1;
  logic [1:0] sym_s = 2'b00;
  always @(posedge clk) begin
    case (sym_s)
      2'b01: if (dec_idx < 16) dec_idx <= dec_idx * 2;
      2'b10: if (dec_idx < 16) dec_idx <= dec_idx * 2 + 1;
      2'b11: dec_idx <= 1;
      default: ;
    endcase
  end
  assign letter_in = heap_char(dec_idx);
  assign done_in   = (dec_idx == 1);

  // Output monitors, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int n_dot = 0, n_dash = 0, n_send = 0, n_b2b = 0;
  logic [1:0] prev_sym = 2'b00;
  always @(negedge clk) begin
    sym_s <= symbol;
    if (!rst) begin
      if (char_valid && char_ready) rx_q.push_back(char_data);
      if (symbol == 2'b01) n_dot <= n_dot + 1;
      if (symbol == 2'b10) n_dash <= n_dash + 1;
      if (symbol == 2'b11) n_send <= n_send + 1;
      if (symbol != 2'b00 && prev_sym != 2'b00) n_b2b <= n_b2b + 1;
      prev_sym <= symbol;
    end else begin
      prev_sym <= 2'b00;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive key level k for n clock edges; inputs change 1 time unit after each edge.
  task automatic hold(input logic k, input int n);
    key = k;
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) begin
        if (!char_ready) char_ready = 1'b1;
        else char_ready = ($urandom_range(3) != 0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         nel;
    int         hi[5];
    logic [7:0] exp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int base;
    logic [7:0] exp_q[$];
    int e_dot, e_dash, e_send, b_dot, b_dash, b_send, b_b2b;

    tbl[0] = '{1, '{3, 0, 0, 0, 0}, 8'h45};  // E
    tbl[1] = '{1, '{4, 0, 0, 0, 0}, 8'h45};  // longest dot
    tbl[2] = '{1, '{5, 0, 0, 0, 0}, 8'h54};  // shortest dash
    tbl[3] = '{2, '{2, 7, 0, 0, 0}, 8'h41};  // A
    tbl[4] = '{2, '{9, 1, 0, 0, 0}, 8'h4E};  // N
    tbl[5] = '{3, '{5, 4, 5, 0, 0}, 8'h4B};  // K
    tbl[6] = '{4, '{1, 1, 1, 1, 0}, 8'h48};  // H
    tbl[7] = '{4, '{2, 2, 6, 6, 0}, 8'h2A};  // undefined ..-- passed through
    tbl[8] = '{5, '{1, 2, 3, 4, 1}, 8'h3F};  // too many elements

    rst = 1'b1; key = 1'b0; char_ready = 1'b1;
    hold(0, 3);
    chk("reset_symbol", 32'(symbol), 32'h3);
    chk("reset_valid", 32'(char_valid), 32'h0);
    chk("reset_data", 32'(char_data), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    hold(0, 3);
    chk("idle_symbol", 32'(symbol), 32'h0);

    // Exact timing of a single dot letter.
    hold(1, 3);
    hold(0, 1);
    chk("E_dot_pulse", 32'(symbol), 32'h1);
    hold(0, 1);
    chk("E_dot_one_cycle", 32'(symbol), 32'h0);
    hold(0, 6);
    chk("E_no_early_send", 32'(symbol), 32'h0);
    hold(0, 1);
    chk("E_send_pulse", 32'(symbol), 32'h3);
    chk("E_not_yet_valid", 32'(char_valid), 32'h0);
    hold(0, 1);
    chk("E_valid", 32'(char_valid), 32'h1);
    chk("E_data", 32'(char_data), 32'h45);
    chk("E_send_one_cycle", 32'(symbol), 32'h0);
    hold(0, 30);

    // Dash.
    base = rx_q.size();
    hold(1, 6);
    hold(0, 1);
    chk("T_dash_pulse", 32'(symbol), 32'h2);
    hold(0, 11);
    chk("T_char", 32'(rx_q[base]), 32'h54);
    hold(0, 30);

    // A followed by a word gap: exactly one space, then silence.
    base = rx_q.size();
    hold(1, 2); hold(0, 2); hold(1, 6);
    hold(0, 25);
    hold(0, 40);
    chk("A_space_count", 32'(rx_q.size() - base), 32'd2);
    chk("A_char", 32'(rx_q[base]), 32'h41);
    chk("A_space", 32'(rx_q[base + 1]), 32'h20);
    chk("A_idle_valid", 32'(char_valid), 32'h0);

    // Table of letters separated by letter gaps.
    for (int r = 0; r < 9; r++) begin
      base = rx_q.size();
      for (int e = 0; e < tbl[r].nel; e++) begin
        hold(1, tbl[r].hi[e]);
        hold(0, (e == tbl[r].nel - 1) ? 12 : 2);
      end
      chk($sformatf("tbl%0d_count", r), 32'(rx_q.size() - base), 32'd1);
      chk($sformatf("tbl%0d_char", r), 32'(rx_q[base]), 32'(tbl[r].exp));
    end
    hold(0, 30);

    // Overrun: consumer stalled while two letters arrive.
    base = rx_q.size();
    char_ready = 1'b0;
    hold(1, 3); hold(0, 12);
    hold(1, 6); hold(0, 12);
    chk("ovr_hold_data", 32'(char_data), 32'h45);
    chk("ovr_hold_valid", 32'(char_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    char_ready = 1'b1;
    hold(0, 1);
    chk("ovr_drained", 32'(char_valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    chk("ovr_accepted", 32'(rx_q[base]), 32'h45);
    hold(0, 30);

    // Reset in the middle of a press.
    hold(1, 2);
    rst = 1'b1;
    hold(1, 1);
    chk("rst1_symbol", 32'(symbol), 32'h3);
    chk("rst1_valid", 32'(char_valid), 32'h0);
    chk("rst1_overrun", 32'(overrun), 32'h0);
    hold(1, 1);
    chk("rst2_symbol", 32'(symbol), 32'h3);
    rst = 1'b0;
    base = rx_q.size();
    hold(0, 30);
    chk("rst_no_push", 32'(rx_q.size() - base), 32'd0);
    hold(1, 2); hold(0, 12);
    chk("rst_then_E", 32'(rx_q[base]), 32'h45);
    hold(0, 30);

    // Randomized words against the reference model.
    base = rx_q.size();
    b_dot = n_dot; b_dash = n_dash; b_send = n_send; b_b2b = n_b2b;
    e_dot = 0; e_dash = 0; e_send = 0;
    rnd_ready = 1'b1;
    for (int w = 0; w < 12; w++) begin
      int nlet;
      nlet = $urandom_range(3, 1);
      for (int l = 0; l < nlet; l++) begin
        int nel, idx;
        nel = ($urandom_range(7) == 0) ? 5 : $urandom_range(4, 1);
        idx = 1;
        for (int e = 0; e < nel; e++) begin
          int len, gap;
          len = $urandom_range(9, 1);
          if (len <= 4) e_dot++; else e_dash++;
          if (e < 4) idx = 2 * idx + ((len <= 4) ? 0 : 1);
          if (e < nel - 1)       gap = $urandom_range(8, 1);
          else if (l < nlet - 1) gap = $urandom_range(20, 10);
          else                   gap = $urandom_range(30, 21);
          hold(1, len);
          hold(0, gap);
        end
        e_send++;
        exp_q.push_back((nel > 4) ? 8'h3F : heap_char(idx));
      end
      exp_q.push_back(8'h20);
    end
    rnd_ready = 1'b0;
    char_ready = 1'b1;
    hold(0, 5);
    chk("rnd_char_count", 32'(rx_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_char%0d", i), 32'(rx_q[base + i]), 32'(exp_q[i]));
    chk("rnd_dots", 32'(n_dot - b_dot), 32'(e_dot));
    chk("rnd_dashes", 32'(n_dash - b_dash), 32'(e_dash));
    chk("rnd_sends", 32'(n_send - b_send), 32'(e_send));
    chk("rnd_back_to_back", 32'(n_b2b - b_b2b), 32'd0);
    chk("rnd_no_overrun", 32'(overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/morse_keyer_ctrl.md
Name: morse_keyer_ctrl

Overview:
Front-end sequencer for the Morse letter decoder FSM. It times a single synchronised key line and classifies each press as dot or dash. It issues one-cycle symbol codes (01 dot, 10 dash, 11 send) to the decoder, captures the decoded ASCII letter at end-of-letter, and inserts ASCII space on word gaps. Characters leave through a one-entry valid/ready output buffer toward the display/UART side.

Parameters:
CNT_W, 16, width of the saturating duration counter
DOT_MAX, 400, longest press (cycles) classified as dot; longer = dash
GAP_LETTER, 1200, key-low cycles after the last element that end a letter
GAP_WORD, 2800, key-low cycles after the last element that end a word (GAP_WORD > GAP_LETTER > 0)
MAX_ELEM, 4, maximum legal elements per letter

Ports:
clk  in  1  system clock
rst  in  1  reset
key  in  1  debounced, synchronised key level (1 = pressed)
symbol  out  2  to decoder inputSignal: 00 idle, 01 dot, 10 dash, 11 send/restart
letter_in  in  8  decoder letter output (combinational from decoder state)
done_in  in  1  decoder done (1 = decoder at start, no letter pending)
char_data  out  8  ASCII character
char_valid  out  1  char_data valid
char_ready  in  1  consumer accepts char when char_valid & char_ready
overrun  out  1  sticky: a character was dropped

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Reset values: symbol=2'b11 (held every reset cycle so the reset-less decoder returns to start), char_valid=0, char_data=0, overrun=0. Internal: state=IDLE, cnt=0, elem_cnt=0.
- cnt saturates at all-ones; no wrap.
- States:
  IDLE: symbol=00. key=1 -> PRESS, cnt<=1, elem_cnt<=0.
  PRESS: key=1 -> cnt++. key=0 -> symbol<=01 if cnt<=DOT_MAX else 10 (exactly one cycle), elem_cnt++ (saturate at MAX_ELEM+1), cnt<=1, -> GAP.
  GAP: key=1 -> PRESS, cnt<=1. key=0 -> cnt++; when cnt==GAP_LETTER -> SEND.
  SEND (1 cycle): symbol=11 is presented. At the end of this cycle, letter_in/done_in are sampled while the decoder still shows the letter. If elem_cnt>MAX_ELEM, push 0x3F ('?'). Else if done_in=0, push letter_in. Else push nothing. -> WORD, cnt keeps counting.
  WORD: key=1 -> PRESS, cnt<=1, elem_cnt<=0. cnt==GAP_WORD -> push 0x20 once -> IDLE.
- Elements are counted in PRESS; a letter with no push (done_in=1) still counts toward a word gap.
- Push rules: if char_valid=0, or char_valid&char_ready in the same cycle, load char_data and set char_valid=1. Otherwise drop the new char and set overrun=1 (sticky until rst). char_valid & char_ready with no push -> char_valid=0.
- char_data is stable while char_valid=1 and char_ready=0.
- Latency: key fall -> symbol pulse on the next cycle. The SEND cycle -> char_valid on the next cycle.
- The symbol is 00 in every cycle not listed above; never two non-zero symbols back to back.
- rst mid-operation: the in-flight letter is abandoned, no char is pushed, and the buffer is cleared.

Decomposition:
- Shared package morse_pkg: symbol codes SYM_IDLE/DOT/DASH/SEND, ASCII_SPACE=8'h20, ASCII_ERR=8'h3F, and the state enum.
- One natural sub-module: morse_char_buf, the one-entry valid/ready holding register with overrun flag.
- The timing FSM stays in the top module.

Test Plan:
(Bench: DOT_MAX=4, GAP_LETTER=8, GAP_WORD=20, reference decoder model attached, char_ready=1 unless stated.)
- Key high 3 cycles, then low -> symbol=01 for one cycle; 8 low cycles later symbol=11 for one cycle; next cycle char_data=0x45 'E', char_valid=1.
- Key high 6 cycles, then low -> symbol=10, then char 0x54 'T'.
- Dot, 2-cycle gap, dash, then key low 20+ cycles -> chars 0x41 'A' then 0x20 exactly once; IDLE afterwards with no further pushes.
- char_ready=0, send 'E' then 'T' -> char_data holds 0x45, 'T' dropped, overrun=1. Raise char_ready -> 0x45 accepted, char_valid=0, overrun remains 1.
- Five dots then letter gap -> char 0x3F '?'.
- Assert rst for 2 cycles during a press -> symbol=11 on both cycles, char_valid=0, overrun=0, no char pushed; the next clean dot decodes 'E'.
